// File: rtl/spi_master_apb_regif.sv
// spi_master_apb_regif
//   APB slave register front-end for the SPI master. Decodes APB accesses
//   into STATUS / CTRL / CLKDIV / TXFIFO registers, buffers transmit words
//   in a circular FIFO and offers the head word to the SPI shift engine
//   over a valid/ready handshake.
//
//   Register map (PADDR):
//     0x0 STATUS (RO) [0] empty [1] full [2] overflow [3] tx_valid [15:8] count
//     0x1 CTRL   (RW) [0] spi_en [3:1] cs_idx, write 1 to [4] clears overflow
//     0x2 CLKDIV (RW) [7:0] divider
//     0x6 TXFIFO (WO) write pushes PWDATA, reads 0
//
//   Ports:
//     HCLK, HRESET                 clock, async active-high reset
//     PADDR[3:0], PSEL, PENABLE,   APB request
//     PWRITE, PWDATA[DW-1:0]
//     PRDATA[DW-1:0], PREADY,      APB response (PREADY tied high)
//     PSLVERR
//     spi_data_tx[DW-1:0]          FIFO head word (0 while empty)
//     spi_data_tx_valid            FIFO non-empty
//     spi_data_tx_ready            engine consumes head when valid & ready
//     spi_cs[NUM_CS-1:0]           one-hot chip select
//     spi_clk_div[7:0], spi_en     engine configuration
//
//   Build option: define SPI_APB_PSLVERR_EN to drive PSLVERR on writes to
//   unmapped addresses, writes to STATUS and pushes while full. Otherwise
//   PSLVERR is tied low.
module spi_master_apb_regif #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned TXFIFO_DEPTH = 8,
   parameter int unsigned NUM_CS       = 4
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic [3:0]            PADDR,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   output logic [DATA_WIDTH-1:0] spi_data_tx,
   output logic                  spi_data_tx_valid,
   input  logic                  spi_data_tx_ready,
   output logic [NUM_CS-1:0]     spi_cs,
   output logic [7:0]            spi_clk_div,
   output logic                  spi_en
);

   localparam int unsigned AW = $clog2(TXFIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [3:0] ADDR_STATUS = 4'h0;
   localparam logic [3:0] ADDR_CTRL   = 4'h1;
   localparam logic [3:0] ADDR_CLKDIV = 4'h2;
   localparam logic [3:0] ADDR_TXFIFO = 4'h6;

   logic [DATA_WIDTH-1:0] r_mem [TXFIFO_DEPTH];
   logic [AW-1:0]         r_wptr;
   logic [AW-1:0]         r_rptr;
   logic [CW-1:0]         r_count;
   logic                  r_ovf;
   logic                  r_en;
   logic [2:0]            r_cs_idx;
   logic [7:0]            r_div;

   logic                  w_acc;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_fifo_wr;
   logic                  w_push;
   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_prdata;
   logic [NUM_CS-1:0]     w_cs;

   assign w_acc     = PSEL & PENABLE;
   assign w_wr      = w_acc & PWRITE;
   assign w_rd      = w_acc & ~PWRITE;
   assign w_full    = (r_count == CW'(TXFIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_fifo_wr = w_wr & (PADDR == ADDR_TXFIFO);
   // full is taken from the pre-edge count, so a concurrent pop never
   // rescues a push that arrives while full
   assign w_push    = w_fifo_wr & ~w_full;
   assign w_pop     = ~w_empty & spi_data_tx_ready;

   // FIFO storage carries no reset; its contents are only observable
   // through the read pointer while count is non-zero
   always_ff @(posedge HCLK) begin
      if (w_push) r_mem[r_wptr] <= PWDATA;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_en     <= 1'b0;
         r_cs_idx <= '0;
         r_div    <= 8'h04;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_fifo_wr & w_full) r_ovf <= 1'b1;
         if (w_wr && PADDR == ADDR_CTRL) begin
            r_en     <= PWDATA[0];
            r_cs_idx <= PWDATA[3:1];
            if (PWDATA[4]) r_ovf <= 1'b0;
         end
         if (w_wr && PADDR == ADDR_CLKDIV) r_div <= PWDATA[7:0];
      end
   end

   // cs_idx values at or beyond NUM_CS match no line and leave all deselected
   always_comb begin
      w_cs = '0;
      for (int unsigned i = 0; i < NUM_CS; i++)
         w_cs[i] = r_en && (r_cs_idx == 3'(i));
   end

   always_comb begin
      w_prdata = '0;
      if (w_rd) begin
         case (PADDR)
            ADDR_STATUS: begin
               w_prdata[0]       = w_empty;
               w_prdata[1]       = w_full;
               w_prdata[2]       = r_ovf;
               w_prdata[3]       = ~w_empty;
               w_prdata[8 +: CW] = r_count;
            end
            ADDR_CTRL: begin
               w_prdata[0]   = r_en;
               w_prdata[3:1] = r_cs_idx;
            end
            ADDR_CLKDIV: w_prdata[7:0] = r_div;
            default:     w_prdata = '0;
         endcase
      end
   end

`ifdef SPI_APB_PSLVERR_EN
   assign PSLVERR = w_wr & (((PADDR != ADDR_CTRL) & (PADDR != ADDR_CLKDIV) &
                             (PADDR != ADDR_TXFIFO)) | (w_fifo_wr & w_full));
`else
   assign PSLVERR = 1'b0;
`endif

   assign PRDATA            = w_prdata;
   assign PREADY            = 1'b1;
   assign spi_data_tx       = w_empty ? '0 : r_mem[r_rptr];
   assign spi_data_tx_valid = ~w_empty;
   assign spi_cs            = w_cs;
   assign spi_clk_div       = r_div;
   assign spi_en            = r_en;

endmodule

// File: tb/tb_spi_master_apb_regif.sv
module tb_spi_master_apb_regif;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned NCS   = 4;

   logic          HCLK = 1'b0;
   logic          HRESET = 1'b1;
   logic [3:0]    PADDR = '0;
   logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [DW-1:0] PWDATA = '0;
   logic [DW-1:0] PRDATA;
   logic          PREADY, PSLVERR;
   logic [DW-1:0] spi_data_tx;
   logic          spi_data_tx_valid;
   logic          spi_data_tx_ready = 1'b0;
   logic [NCS-1:0] spi_cs;
   logic [7:0]    spi_clk_div;
   logic          spi_en;

   int n_tests = 0;
   int n_fail  = 0;

   spi_master_apb_regif #(.DATA_WIDTH(DW), .TXFIFO_DEPTH(DEPTH), .NUM_CS(NCS)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR), .spi_data_tx(spi_data_tx), .spi_data_tx_valid(spi_data_tx_valid),
      .spi_data_tx_ready(spi_data_tx_ready), .spi_cs(spi_cs),
      .spi_clk_div(spi_clk_div), .spi_en(spi_en)
   );

   always #5 HCLK = ~HCLK;

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_q[$];
   bit            m_ovf;
   bit            m_en;
   int unsigned   m_cs;
   int unsigned   m_div = 4;

   always @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         m_q.delete();
         m_ovf = 0; m_en = 0; m_cs = 0; m_div = 4;
      end else begin
         int unsigned pre;
         bit wr;
         pre = m_q.size();
         wr  = PSEL && PENABLE && PWRITE;
         if (pre > 0 && spi_data_tx_ready) void'(m_q.pop_front());
         if (wr && PADDR == 4'h6) begin
            if (pre < DEPTH) m_q.push_back(PWDATA);
            else             m_ovf = 1;
         end
         if (wr && PADDR == 4'h1) begin
            m_en = PWDATA[0];
            m_cs = int'(PWDATA[3:1]);
            if (PWDATA[4]) m_ovf = 0;
         end
         if (wr && PADDR == 4'h2) m_div = int'(PWDATA[7:0]);
      end
   end

   function automatic logic [DW-1:0] m_read(input logic [3:0] a);
      int unsigned n;
      n = m_q.size();
      case (a)
         4'h0: return DW'((n == 0) + 2*(n == DEPTH) + 4*m_ovf + 8*(n != 0) + 256*n);
         4'h1: return DW'(m_en + 2*m_cs);
         4'h2: return DW'(m_div);
         default: return '0;
      endcase
   endfunction

   function automatic logic m_slverr();
      bit wr;
      wr = PSEL && PENABLE && PWRITE;
`ifdef SPI_APB_PSLVERR_EN
      return wr && (!(PADDR inside {4'h1, 4'h2, 4'h6}) ||
                    (PADDR == 4'h6 && m_q.size() == DEPTH));
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison against the model, mid-cycle
   always @(negedge HCLK) begin
      if (!HRESET) begin
         check("valid", DW'(spi_data_tx_valid), DW'(m_q.size() != 0));
         if (m_q.size() != 0) check("head", spi_data_tx, m_q[0]);
         check("cs", DW'(spi_cs), (m_en && m_cs < NCS) ? DW'(1) << m_cs : '0);
         check("clkdiv", DW'(spi_clk_div), DW'(m_div));
         check("en", DW'(spi_en), DW'(m_en));
         check("pready", DW'(PREADY), DW'(1));
         check("pslverr", DW'(PSLVERR), DW'(m_slverr()));
      end
   end

   // ---------------- stimulus ----------------
   task automatic apb_write(input logic [3:0] a, input logic [DW-1:0] d,
                            input logic sel = 1'b1, input logic en = 1'b1);
      PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = sel; PENABLE = en;
      @(posedge HCLK); #2;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [3:0] a, output logic [DW-1:0] d);
      PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b1;
      #1;
      d = PRDATA;
      check("prdata_model", d, m_read(a));
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] rd;
      repeat (3) @(posedge HCLK);
      #2 HRESET = 1'b0;

      // reset state
      apb_read(4'h0, rd);
      check("reset_status", rd, 32'h0000_0001);
      check("reset_clkdiv", DW'(spi_clk_div), 32'h04);
      check("reset_cs", DW'(spi_cs), 32'h0);

      // only an enabled write to TXFIFO pushes
      apb_write(4'h6, 32'hA5);
      apb_write(4'h7, 32'hA5);
      apb_write(4'h4, 32'hA5);
      apb_write(4'hE, 32'hA5);
      apb_write(4'h6, 32'hA5, 1'b1, 1'b0);
      apb_write(4'h6, 32'hA5, 1'b0, 1'b1);
      apb_read(4'h6, rd);
      check("txfifo_read", rd, 32'h0);
      apb_read(4'h0, rd);
      check("single_push_status", rd, 32'h0000_0108);
      check("single_push_head", spi_data_tx, 32'hA5);
      apb_write(4'h0, 32'hFF);
      spi_data_tx_ready = 1'b1;
      @(posedge HCLK); #2;
      spi_data_tx_ready = 1'b0;

      // fill past full, then drain in order
      for (int i = 0; i <= 8; i++) apb_write(4'h6, DW'(i));
      apb_read(4'h0, rd);
      check("full_status", rd, 32'h0000_080E);
      spi_data_tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("drain_order", spi_data_tx, DW'(i));
         @(posedge HCLK); #2;
      end
      spi_data_tx_ready = 1'b0;
      apb_read(4'h0, rd);
      check("drained_status", rd, 32'h0000_0005);
      apb_write(4'h1, 32'h10);

      // simultaneous push and pop at 7 entries and at full
      for (int i = 0; i < 7; i++) apb_write(4'h6, 32'h100 + DW'(i));
      spi_data_tx_ready = 1'b1;
      apb_write(4'h6, 32'h107);
      spi_data_tx_ready = 1'b0;
      apb_read(4'h0, rd);
      check("pushpop7_status", rd, 32'h0000_0708);
      apb_write(4'h6, 32'h108);
      spi_data_tx_ready = 1'b1;
      apb_write(4'h6, 32'hDEAD);
      spi_data_tx_ready = 1'b0;
      apb_read(4'h0, rd);
      check("pushpop_full_status", rd, 32'h0000_070C);
      check("pushpop_full_head", spi_data_tx, 32'h102);
      spi_data_tx_ready = 1'b1;
      repeat (10) @(posedge HCLK);
      #2 spi_data_tx_ready = 1'b0;
      apb_write(4'h1, 32'h10);

      // chip select decode
      apb_write(4'h1, 32'h0B);
      check("cs_out_of_range", DW'(spi_cs), 32'h0);
      apb_write(4'h1, 32'h05);
      check("cs_idx2", DW'(spi_cs), 32'h4);
      apb_read(4'h1, rd);
      check("ctrl_read", rd, 32'h05);
      apb_write(4'h2, 32'h3C);
      apb_read(4'h2, rd);
      check("clkdiv_read", rd, 32'h3C);

      // asynchronous reset mid-transfer
      for (int i = 0; i < 3; i++) apb_write(4'h6, 32'hC0 + DW'(i));
      #1 HRESET = 1'b1;
      #1 check("async_valid_drop", DW'(spi_data_tx_valid), 32'h0);
      #2 HRESET = 1'b0;
      @(posedge HCLK); #2;
      apb_read(4'h0, rd);
      check("post_reset_status", rd, 32'h0000_0001);
      check("post_reset_clkdiv", DW'(spi_clk_div), 32'h04);
      check("post_reset_cs", DW'(spi_cs), 32'h0);

      repeat (2) @(posedge HCLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
